// File: rtl/intctl_pkg.sv
// Exception codes, register indices and sizing shared by the CPU,
// the SoC top and the interrupt controller.
package intctl_pkg;

    localparam int NSRC = 7;

    typedef logic [NSRC-1:0] src_vec_t;
    typedef logic [2:0]      exc_code_t;
    typedef logic [1:0]      reg_idx_t;

    localparam exc_code_t EXC_RESET    = 3'd0;
    localparam exc_code_t EXC_MMU      = 3'd1;
    localparam exc_code_t EXC_TIMER3   = 3'd2;
    localparam exc_code_t EXC_TIMER2   = 3'd3;
    localparam exc_code_t EXC_TIMER1   = 3'd4;
    localparam exc_code_t EXC_TIMER0   = 3'd5;
    localparam exc_code_t EXC_UART0_RX = 3'd6;
    localparam exc_code_t EXC_UART0_TX = 3'd7;

    localparam reg_idx_t REG_PENDING = 2'd0;
    localparam reg_idx_t REG_ENABLE  = 2'd1;
    localparam reg_idx_t REG_EDGE    = 2'd2;
    localparam reg_idx_t REG_ACTIVE  = 2'd3;

    localparam src_vec_t ENABLE_RST = 7'h40;
    localparam src_vec_t EDGE_RST   = 7'h00;

    localparam logic [3:0] INTCTL_CS = 4'h5;

    // Source k maps to code 7-k, so the MMU on bit 6 gets code 1.
    function automatic exc_code_t src_to_code(input int unsigned k);
        return exc_code_t'(7 - k);
    endfunction

endpackage

// File: rtl/intctl_if.sv
// Wishbone slave bundle for the interrupt controller register window.
interface intctl_if;

    logic        cyc_i;
    logic        stb_i;
    logic        we_i;
    logic [1:0]  adr_i;
    logic [3:0]  sel_i;
    logic [31:0] dat_i;
    logic [31:0] dat_o;
    logic        ack_o;

    modport master (
        output cyc_i, stb_i, we_i, adr_i, sel_i, dat_i,
        input  dat_o, ack_o
    );

    modport slave (
        input  cyc_i, stb_i, we_i, adr_i, sel_i, dat_i,
        output dat_o, ack_o
    );

endinterface

// File: rtl/intctl_prio.sv
// Combinational priority encoder: highest set request bit wins,
// producing its exception code; no request gives EXC_RESET.
module intctl_prio
    import intctl_pkg::*;
(
    input  src_vec_t  req,
    output exc_code_t code
);

    always_comb begin
        code = EXC_RESET;
        for (int unsigned k = 0; k < NSRC; k++) begin
            if (req[k]) code = src_to_code(k);
        end
    end

endmodule

// File: rtl/intctl.sv
// Registered interrupt controller: per-source level/edge capture,
// enable masking, priority encoding and a Wishbone register window.
module intctl
    import intctl_pkg::*;
(
    input  logic      clk_i,
    input  logic      rst_n_i,
    input  src_vec_t  src_i,
    input  logic      int_en_i,
    output exc_code_t inter_o,
    intctl_if.slave   wb
);

    src_vec_t  src_q;
    src_vec_t  pending;
    src_vec_t  enable;
    src_vec_t  edge_sel;

    logic      access;
    logic      wr;
    src_vec_t  wdat;
    src_vec_t  clr;
    src_vec_t  rise;
    src_vec_t  edge_nxt;
    src_vec_t  edge_chg;
    src_vec_t  pend_nxt;
    src_vec_t  en_nxt;
    logic [31:0] rdata;
    exc_code_t code;
    logic      unused_bits;

    assign unused_bits = ^{wb.dat_i[31:NSRC], wb.sel_i[3:1]};

    assign access = wb.cyc_i & wb.stb_i & ~wb.ack_o;
    assign wr     = access & wb.we_i & wb.sel_i[0];
    assign wdat   = wb.dat_i[NSRC-1:0];
    assign rise   = src_i & ~src_q;

    always_comb begin
        clr      = '0;
        edge_nxt = edge_sel;
        en_nxt   = enable;
        if (wr) begin
            unique case (wb.adr_i)
                REG_PENDING: clr      = wdat;
                REG_ENABLE:  en_nxt   = wdat | ENABLE_RST;
                REG_EDGE:    edge_nxt = wdat;
                REG_ACTIVE:  ;
            endcase
        end
    end

    // A mode change discards whatever was captured under the old mode.
    assign edge_chg = edge_nxt ^ edge_sel;
    assign pend_nxt = ((edge_sel & (rise | (pending & ~clr)))
                     | (~edge_sel & src_i)) & ~edge_chg;

    always_comb begin
        rdata = '0;
        unique case (wb.adr_i)
            REG_PENDING: rdata[NSRC-1:0] = pending;
            REG_ENABLE:  rdata[NSRC-1:0] = enable;
            REG_EDGE:    rdata[NSRC-1:0] = edge_sel;
            REG_ACTIVE:  rdata[3:0]      = {int_en_i, inter_o};
        endcase
    end

    intctl_prio u_prio (
        .req  (pending & enable),
        .code (code)
    );

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            src_q    <= '0;
            pending  <= '0;
            enable   <= ENABLE_RST;
            edge_sel <= EDGE_RST;
            inter_o  <= EXC_RESET;
            wb.ack_o <= 1'b0;
            wb.dat_o <= '0;
        end else begin
            src_q    <= src_i;
            pending  <= pend_nxt;
            enable   <= en_nxt;
            edge_sel <= edge_nxt;
            inter_o  <= int_en_i ? code : EXC_RESET;
            wb.ack_o <= access;
            wb.dat_o <= access ? rdata : '0;
        end
    end

endmodule

// File: tb/tb_intctl.sv
// Directed scoreboard bench for intctl: register map, level/edge capture,
// masking, priority, handshake and asynchronous reset.
module tb_intctl;
    import intctl_pkg::*;

    logic      clk;
    logic      rst_n;
    src_vec_t  src;
    logic      int_en;
    exc_code_t inter;

    intctl_if wb ();

    intctl dut (
        .clk_i    (clk),
        .rst_n_i  (rst_n),
        .src_i    (src),
        .int_en_i (int_en),
        .inter_o  (inter),
        .wb       (wb.slave)
    );

    typedef struct {
        string       tag;
        logic [31:0] val;
    } exp_t;

    exp_t sb[$];
    int   n_cmp;
    int   n_err;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: sim time limit reached, got hang want $finish");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_val(input string tag, input logic [31:0] v);
        exp_t e;
        e.tag = tag;
        e.val = v;
        sb.push_back(e);
    endtask

    task automatic check(input logic [31:0] obs);
        exp_t e;
        n_cmp++;
        if (sb.size() == 0) begin
            n_err++;
            $error("FAIL scoreboard_empty: got %0h want <entry>", obs);
        end else begin
            e = sb.pop_front();
            assert (obs === e.val) else begin
                n_err++;
                $error("FAIL %s: got %0h want %0h", e.tag, obs, e.val);
            end
        end
    endtask

    task automatic check_inter(input string tag, input exc_code_t v);
        expect_val(tag, {29'b0, v});
        check({29'b0, inter});
    endtask

    task automatic wb_read(input reg_idx_t a, input string tag,
                           input logic [31:0] v);
        wb.cyc_i = 1'b1;
        wb.stb_i = 1'b1;
        wb.we_i  = 1'b0;
        wb.adr_i = a;
        expect_val({tag, "_ack"}, 32'd1);
        expect_val(tag, v);
        tick();
        check({31'b0, wb.ack_o});
        check(wb.dat_o);
        wb.cyc_i = 1'b0;
        wb.stb_i = 1'b0;
        tick();
    endtask

    task automatic wb_write(input reg_idx_t a, input logic [3:0] sel,
                            input logic [31:0] d);
        wb.cyc_i = 1'b1;
        wb.stb_i = 1'b1;
        wb.we_i  = 1'b1;
        wb.adr_i = a;
        wb.sel_i = sel;
        wb.dat_i = d;
        expect_val("wr_ack", 32'd1);
        tick();
        check({31'b0, wb.ack_o});
        wb.cyc_i = 1'b0;
        wb.stb_i = 1'b0;
        wb.we_i  = 1'b0;
        wb.sel_i = 4'h0;
        tick();
    endtask

    initial begin
        n_cmp    = 0;
        n_err    = 0;
        rst_n    = 1'b0;
        src      = '0;
        int_en   = 1'b0;
        wb.cyc_i = 1'b0;
        wb.stb_i = 1'b0;
        wb.we_i  = 1'b0;
        wb.adr_i = '0;
        wb.sel_i = '0;
        wb.dat_i = '0;

        tick();
        tick();
        check_inter("rst_inter", EXC_RESET);
        expect_val("rst_ack", 32'd0);
        check({31'b0, wb.ack_o});
        rst_n = 1'b1;
        tick();

        wb_read(REG_PENDING, "rst_pending", 32'h0);
        wb_read(REG_ENABLE,  "rst_enable",  32'h40);
        wb_read(REG_EDGE,    "rst_edge",    32'h0);
        wb_read(REG_ACTIVE,  "rst_active",  32'h0);

        // Level mode
        int_en = 1'b1;
        wb_write(REG_ENABLE, 4'hF, 32'h7F);
        src = 7'h04;
        tick();
        check_inter("lvl_t0_early", EXC_RESET);
        tick();
        check_inter("lvl_t0", EXC_TIMER0);
        src = 7'h24;
        tick();
        tick();
        check_inter("lvl_t3", EXC_TIMER3);
        src = 7'h00;
        tick();
        check_inter("lvl_drop_early", EXC_TIMER3);
        tick();
        check_inter("lvl_drop", EXC_RESET);

        // Edge mode on UART0_RX
        wb_write(REG_EDGE, 4'hF, 32'h02);
        src = 7'h02;
        tick();
        src = 7'h00;
        tick();
        check_inter("edge_rx", EXC_UART0_RX);
        wb_read(REG_PENDING, "edge_pending", 32'h02);
        check_inter("edge_hold", EXC_UART0_RX);
        wb_write(REG_PENDING, 4'hF, 32'h02);
        check_inter("edge_w1c", EXC_RESET);
        src = 7'h02;
        wb_write(REG_PENDING, 4'hF, 32'h02);
        src = 7'h00;
        wb_read(REG_PENDING, "set_wins", 32'h02);

        // Back to level, masking by int_en and MMU lock
        wb_write(REG_EDGE, 4'hF, 32'h00);
        src = 7'h7F;
        int_en = 1'b0;
        tick();
        tick();
        check_inter("int_dis", EXC_RESET);
        int_en = 1'b1;
        tick();
        check_inter("int_en_mmu", EXC_MMU);
        wb_write(REG_ENABLE, 4'hF, 32'h00);
        wb_read(REG_ENABLE, "mmu_locked", 32'h40);
        check_inter("mmu_still", EXC_MMU);
        wb_read(REG_ACTIVE, "active", 32'h9);
        wb_write(REG_ENABLE, 4'hE, 32'h7F);
        wb_read(REG_ENABLE, "sel_gate", 32'h40);

        // Held strobe: ack alternates, one per accepted strobe
        wb.cyc_i = 1'b1;
        wb.stb_i = 1'b1;
        wb.we_i  = 1'b0;
        wb.adr_i = REG_ENABLE;
        for (int i = 0; i < 4; i++) begin
            expect_val("b2b_ack", (i % 2 == 0) ? 32'd1 : 32'd0);
            expect_val("b2b_dat", (i % 2 == 0) ? 32'h40 : 32'h0);
            tick();
            check({31'b0, wb.ack_o});
            check(wb.dat_o);
        end
        wb.cyc_i = 1'b0;
        wb.stb_i = 1'b0;
        tick();

        // Async reset in the middle of an acked read with edge bits pending
        wb_write(REG_EDGE, 4'hF, 32'h7F);
        src = 7'h00;
        tick();
        src = 7'h7F;
        tick();
        tick();
        check_inter("pre_rst", EXC_MMU);
        wb.cyc_i = 1'b1;
        wb.stb_i = 1'b1;
        wb.adr_i = REG_PENDING;
        expect_val("pre_rst_ack", 32'd1);
        expect_val("pre_rst_dat", 32'h7F);
        tick();
        check({31'b0, wb.ack_o});
        check(wb.dat_o);
        #2;
        rst_n = 1'b0;
        #1;
        expect_val("arst_ack", 32'd0);
        check({31'b0, wb.ack_o});
        expect_val("arst_dat", 32'd0);
        check(wb.dat_o);
        check_inter("arst_inter", EXC_RESET);
        wb.cyc_i = 1'b0;
        wb.stb_i = 1'b0;
        src = 7'h00;
        tick();
        rst_n = 1'b1;
        tick();
        wb_read(REG_PENDING, "post_pending", 32'h0);
        wb_read(REG_ENABLE,  "post_enable",  32'h40);
        wb_read(REG_EDGE,    "post_edge",    32'h0);
        wb_read(REG_ACTIVE,  "post_active",  32'h8);

        n_cmp++;
        assert (sb.size() == 0) else begin
            n_err++;
            $error("FAIL scoreboard_left: got %0d want 0", sb.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
